// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit for the E stage: runs mult/multu/div/divu/madd
// over a fixed cycle count and owns the architectural HI/LO registers.
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdu_start,
  input  logic [2:0]  mdu_mod,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        state_dbg
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [63:0]    res, res_nx;
  logic [31:0]    hi_q, lo_q, hi_nx, lo_nx;

  logic           is_op, is_div, b_nz;
  logic [63:0]    smul, umul, madd_sum, calc_res;
  logic [31:0]    abs_a, abs_b, div_b, div_abs_b;
  logic [31:0]    uq, ur, q_mag, r_mag, sq, sr;

  // Handshake: mdu_start is a one-cycle request accepted only in IDLE; busy is
  // high whenever a request is present or an operation is in flight, and the
  // hazard unit must hold further md-class instructions while busy is high.
  assign busy      = mdu_start | (state == RUN);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state;

  assign is_op  = mdu_start && (mdu_mod inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD});
  assign is_div = (mdu_mod == OP_DIV) || (mdu_mod == OP_DIVU);
  assign b_nz   = (b != 32'd0);

  assign smul     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul     = {32'd0, a} * {32'd0, b};
  assign madd_sum = {hi_q, lo_q} + smul;

  // Divisors are forced to 1 on b==0 so the arithmetic stays defined; the
  // result is discarded in that case anyway.
  assign div_b     = b_nz ? b : 32'd1;
  assign uq        = a / div_b;
  assign ur        = a % div_b;
  assign abs_a     = a[31] ? -a : a;
  assign abs_b     = b[31] ? -b : b;
  assign div_abs_b = b_nz ? abs_b : 32'd1;
  assign q_mag     = abs_a / div_abs_b;
  assign r_mag     = abs_a % div_abs_b;
  // Magnitude division makes 0x80000000 / -1 wrap back to 0x80000000 with no remainder.
  assign sq        = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign sr        = a[31] ? -r_mag : r_mag;

  always_comb begin
    calc_res = {hi_q, lo_q};
    case (mdu_mod)
      OP_MULT:  calc_res = smul;
      OP_MULTU: calc_res = umul;
      OP_MADD:  calc_res = madd_sum;
      OP_DIV:   calc_res = b_nz ? {sr, sq} : {hi_q, lo_q};
      OP_DIVU:  calc_res = b_nz ? {ur, uq} : {hi_q, lo_q};
      default:  calc_res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    res_nx   = res;
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    case (state)
      IDLE: begin
        if (is_op) begin
          res_nx   = calc_res;
          cnt_nx   = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
          state_nx = RUN;
        end else if (!mdu_start) begin
          if (mdu_mod == OP_MTHI) hi_nx = a;
          if (mdu_mod == OP_MTLO) lo_nx = a;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          hi_nx    = res[63:32];
          lo_nx    = res[31:0];
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      res   <= res_nx;
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit of the P6 five-stage MIPS core, living in the E stage directly downstream of the instruction decoder. It consumes the decoder's `mdu_start`/`mdu_mod` controls plus the two forwarded E-stage operands. It runs mult/multu/div/divu/madd over several cycles and holds the architectural HI/LO registers. It exports `busy` so the hazard unit can stall any D-stage md-class instruction (`is_md_instr`).

## Interface
Parameters:
- `MUL_CYCLES`, 5, execution cycles for mult/multu/madd (≥1)
- `DIV_CYCLES`, 10, execution cycles for div/divu (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `mdu_start`  in  1  E-stage start pulse from the decoder (mult/multu/div/divu/madd)
- `mdu_mod`  in  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 none
- `a`  in  32  rs value (forwarded)
- `b`  in  32  rt value (forwarded)
- `busy`  out  1  `mdu_start` OR operation in flight
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Two states: IDLE and RUN. A down-counter `cnt` and a latched 64-bit result `res` go with them.
- IDLE, edge with `mdu_start`=1 and `mdu_mod` ∈ {000,001,010,011,110}:
  - capture the op and compute `res`;
  - load `cnt` with MUL_CYCLES or DIV_CYCLES;
  - go to RUN.
- If `mdu_start`=1 with any other `mdu_mod`, treat it as no-op.
- RUN: decrement `cnt` each edge. On the edge where `cnt`==1, commit `res` to {HI,LO}, set `cnt`=0 and return to IDLE. Operand inputs are ignored in RUN.
- Arithmetic:
  - mult: {HI,LO} = signed a × signed b (64-bit product).
  - multu: {HI,LO} = unsigned a × unsigned b.
  - madd: {HI,LO} = {HI,LO} + signed a × signed b, modulo 2^64. Uses the HI/LO value at the start edge.
  - div: LO = a/b truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient to LO, unsigned remainder to HI.
  - Divide by zero (div/divu with b==0): runs the full DIV_CYCLES, then HI/LO are left unchanged.
- mthi/mtlo (100/101) are single-cycle and need no start:
  - in IDLE with `mdu_start`=0, the next edge writes `a` into HI (or LO);
  - in RUN they are ignored; the hazard unit prevents this case.
- `mdu_start` while in RUN is ignored; the in-flight operation completes undisturbed.
- `hi`/`lo` always show the committed registers. Intermediate results are never visible.

## Timing
- Reset (`reset_n`=0, async): state=IDLE, `cnt`=0, HI=LO=0, `res`=0. `busy` then follows `mdu_start` combinationally.
- Reset asserted mid-operation aborts the operation immediately. No commit happens and HI/LO read 0.
- `busy` = `mdu_start` | (state==RUN). It is combinational on `mdu_start`, so the instruction following a start already sees a stall.
- Start at edge T:
  - `busy` is high in the start cycle and for N cycles after T;
  - HI/LO update at edge T+N;
  - `busy` falls after T+N, where N = MUL_CYCLES or DIV_CYCLES.
- A new start is accepted on the edge after the commit, i.e. on the first cycle `busy` is driven only by `mdu_start`.
- mthi/mtlo at edge T are visible on `hi`/`lo` after T. `busy` stays low.

## Test plan
- Reset then idle:
  - `reset_n`=0 → hi=lo=0, busy=0;
  - release, then mult a=0xFFFFFFFF, b=2 → busy high 6 cycles; after 5 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE at edge T+5.
- madd after mthi 0, mtlo 0xFFFFFFFF, with a=1, b=1 → hi=1, lo=0.
- Signed division:
  - div a=-7 (0xFFFFFFF9), b=2 → after 10 edges lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: divu with b=0 after mtlo 0x1234 → busy 11 cycles, then lo=0x1234 and hi unchanged.
- Busy corner cases:
  - second `mdu_start` and an mthi issued during RUN are both ignored, and the first op's result commits on schedule;
  - `reset_n` pulsed at RUN cycle 3 → hi=lo=0, busy=0, no late commit.
